// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit arbiter: frame geometry,
// arbiter FSM states and the baud divider calculation.
package uart_pkg;

    // Start bit + 8 data bits + stop bit.
    localparam int FRAME_BITS = 10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2
    } arb_state_t;

    // System clocks per serial bit (integer division, same as the transmitter).
    function automatic int calc_baud_cnt_max(input int clk_freq, input int bps);
        return clk_freq / bps;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin finder: returns the first set bit of req,
// searching upward from ptr and wrapping modulo N.
module rr_pick #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic          any,
    output logic [IW-1:0] idx
);

    logic [IW:0]   sum;
    logic [IW-1:0] cand;

    // Scan offsets from the farthest to the nearest so the nearest set bit wins.
    always_comb begin
        // NOTE: every variable gets a default before any conditional write,
        // otherwise the tool infers a latch to hold the old value.
        any  = |req;
        idx  = '0;
        sum  = '0;
        cand = '0;
        for (int k = N - 1; k >= 0; k--) begin
            sum  = {1'b0, ptr} + (IW + 1)'(k);
            cand = (sum >= (IW + 1)'(N)) ? IW'(sum - (IW + 1)'(N)) : sum[IW-1:0];
            if (req[cand]) begin
                idx = cand;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one 8N1 UART transmitter between NUM_REQ
// byte producers. The transmitter has no busy/done output, so this block
// latches the granted byte, fires one start pulse and then times out the
// whole frame plus a guard gap before granting again.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NUM_REQ  = 4,
    parameter int UART_BPS = 9600,
    parameter int CLK_FREQ = 50_000_000,
    parameter int GAP_BITS = 1
) (
    input  logic                       sys_clk,
    input  logic                       sys_rst,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [8*NUM_REQ-1:0]       req_data,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic [7:0]                 tx_data,
    output logic                       tx_start,
    output logic                       busy,
    output logic [$clog2(NUM_REQ)-1:0] grant_id
);

    localparam int IW           = $clog2(NUM_REQ);
    localparam int BAUD_CNT_MAX = calc_baud_cnt_max(CLK_FREQ, UART_BPS);
    // +2 covers the transmitter's flag-to-enable and bit_flag pipeline delay.
    localparam int FRAME_CYCLES = (FRAME_BITS + GAP_BITS) * BAUD_CNT_MAX + 2;
    localparam int CNT_W        = $clog2(FRAME_CYCLES + 1);

    if (BAUD_CNT_MAX < 2) begin : g_baud_check
        $error("uart_tx_arbiter: CLK_FREQ/UART_BPS must be at least 2");
    end

    if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_num_req_check
        $error("uart_tx_arbiter: NUM_REQ must be in 2..8");
    end

    arb_state_t       state;
    logic [IW-1:0]    rr_ptr;
    logic [CNT_W-1:0] frame_cnt;

    logic             pick_any;
    logic [IW-1:0]    pick_idx;
    logic [IW-1:0]    next_ptr;
    logic [7:0]       req_bytes [NUM_REQ];

    rr_pick #(
        .N  (NUM_REQ),
        .IW (IW)
    ) u_rr_pick (
        .req (req_valid),
        .ptr (rr_ptr),
        .any (pick_any),
        .idx (pick_idx)
    );

    // Split the flat data bus into one byte per requester.
    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            req_bytes[i] = req_data[8*i +: 8];
        end
    end

    // Pointer moves to the requester just after the one last served.
    assign next_ptr = (grant_id == IW'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;

    // Acknowledge the picked requester only while idle and out of reset.
    always_comb begin
        req_ready = '0;
        if (!sys_rst && state == IDLE && pick_any) begin
            req_ready[pick_idx] = 1'b1;
        end
    end

    // Arbiter FSM: accept a byte, pulse start, then time out frame + gap.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            frame_cnt <= '0;
            tx_data   <= 8'h00;
            tx_start  <= 1'b0;
            busy      <= 1'b0;
            grant_id  <= '0;
        end else begin
            // NOTE: state is written with <= so every branch sees the values
            // from before this edge; a blocking = here would create
            // order-dependent behaviour and simulation/synthesis mismatch.
            tx_start <= 1'b0;
            case (state)
                IDLE: begin
                    if (pick_any) begin
                        tx_data  <= req_bytes[pick_idx];
                        grant_id <= pick_idx;
                        busy     <= 1'b1;
                        tx_start <= 1'b1;
                        state    <= START;
                    end
                end
                START: begin
                    frame_cnt <= CNT_W'(FRAME_CYCLES - 1);
                    state     <= WAIT;
                end
                WAIT: begin
                    if (frame_cnt == '0) begin
                        state  <= IDLE;
                        busy   <= 1'b0;
                        rr_ptr <= next_ptr;
                    end else begin
                        frame_cnt <= frame_cnt - 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a scoreboard of expected
// (grant, byte) pairs pushed on accept and popped on each start pulse.
module tb_uart_tx_arbiter;
    import uart_pkg::*;

    localparam int NUM_REQ      = 4;
    localparam int CLK_FREQ     = 1_000_000;
    localparam int UART_BPS     = 100_000;
    localparam int GAP_BITS     = 1;
    localparam int FRAME_CYCLES = 112;
    localparam int SPACING      = FRAME_CYCLES + 2;

    logic        sys_clk = 1'b0;
    logic        sys_rst;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_ready;
    logic [7:0]  tx_data;
    logic        tx_start;
    logic        busy;
    logic [1:0]  grant_id;

    typedef struct packed {
        logic [1:0] id;
        logic [7:0] data;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc    = 0;

    uart_tx_arbiter #(
        .NUM_REQ  (NUM_REQ),
        .UART_BPS (UART_BPS),
        .CLK_FREQ (CLK_FREQ),
        .GAP_BITS (GAP_BITS)
    ) dut (
        .sys_clk   (sys_clk),
        .sys_rst   (sys_rst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .tx_data   (tx_data),
        .tx_start  (tx_start),
        .busy      (busy),
        .grant_id  (grant_id)
    );

    always #5 sys_clk = ~sys_clk;

    always @(posedge sys_clk) cyc++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_byte(input int i, input logic [7:0] d);
        req_data[8*i +: 8] = d;
    endtask

    // Wait (bounded) for any ready, check the mask and push the expectation.
    task automatic accept(input string tag, input logic [3:0] exp_mask,
                          input int budget, output int at);
        bit   ok;
        exp_t e;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            #1;
            if (req_ready !== 4'b0) begin
                ok = 1'b1;
                break;
            end
            @(negedge sys_clk);
        end
        check({tag, "_seen"}, 32'(ok), 32'd1);
        check({tag, "_ready"}, 32'(req_ready), 32'(exp_mask));
        at = cyc;
        if (ok) begin
            for (int j = 0; j < NUM_REQ; j++) begin
                if (exp_mask[j]) begin
                    e.id   = 2'(j);
                    e.data = req_data[8*j +: 8];
                end
            end
            sb.push_back(e);
        end
    endtask

    task automatic wait_idle(input string tag, input int budget);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            #1;
            if (busy === 1'b0) begin
                ok = 1'b1;
                break;
            end
            @(negedge sys_clk);
        end
        check({tag, "_idle"}, 32'(ok), 32'd1);
    endtask

    // Monitor: compare each start pulse against the scoreboard and check
    // that tx_data held its value until the frame ended.
    bit         in_frame = 1'b0;
    logic [7:0] frame_data;
    always @(negedge sys_clk) begin
        if (sys_rst) begin
            in_frame = 1'b0;
        end else if (tx_start === 1'b1) begin
            check("sb_nonempty", 32'(sb.size() > 0), 32'd1);
            if (sb.size() > 0) begin
                exp_t e;
                e = sb.pop_front();
                check("mon_tx_data", 32'(tx_data), 32'(e.data));
                check("mon_grant_id", 32'(grant_id), 32'(e.id));
            end
            frame_data = tx_data;
            in_frame   = 1'b1;
        end else if (in_frame && busy === 1'b0) begin
            check("mon_tx_data_hold", 32'(tx_data), 32'(frame_data));
            in_frame = 1'b0;
        end
    end

    initial begin
        int t;
        int prev;
        int c5;
        bit any_ready;

        sys_rst   = 1'b1;
        req_valid = 4'b0;
        req_data  = '0;
        repeat (3) @(negedge sys_clk);
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_tx_start", 32'(tx_start), 32'd0);
        check("rst_tx_data", 32'(tx_data), 32'h00);
        check("rst_grant_id", 32'(grant_id), 32'd0);
        check("rst_ready", 32'(req_ready), 32'd0);

        // Single request from requester 2.
        @(negedge sys_clk);
        sys_rst   = 1'b0;
        req_valid = 4'b0100;
        set_byte(2, 8'hA5);
        accept("single", 4'b0100, 1, t);
        @(negedge sys_clk);
        req_valid = 4'b0;
        #1;
        check("single_start_hi", 32'(tx_start), 32'd1);
        check("single_busy_hi", 32'(busy), 32'd1);
        check("single_grant", 32'(grant_id), 32'd2);
        @(negedge sys_clk);
        #1;
        check("single_start_lo", 32'(tx_start), 32'd0);
        repeat (SPACING - 3) @(negedge sys_clk);
        #1;
        check("single_busy_113", 32'(busy), 32'd1);
        @(negedge sys_clk);
        #1;
        check("single_busy_114", 32'(busy), 32'd0);

        // All four valid from reset: strict rotation 0,1,2,3,0.
        @(negedge sys_clk);
        sys_rst   = 1'b1;
        req_valid = 4'b1111;
        for (int i = 0; i < 4; i++) set_byte(i, 8'(8'h10 + i));
        repeat (2) @(negedge sys_clk);
        sys_rst = 1'b0;
        prev    = 0;
        for (int k = 0; k < 5; k++) begin
            accept($sformatf("rot%0d", k), 4'(1 << (k % 4)), 300, t);
            if (k > 0) check($sformatf("rot%0d_spacing", k), 32'(t - prev), 32'(SPACING));
            prev = t;
            @(negedge sys_clk);
        end
        c5 = prev;

        // Requests arriving during WAIT stay unacknowledged; requester 1
        // drops out before its turn and is skipped.
        req_valid = 4'b0011;
        set_byte(0, 8'h20);
        set_byte(1, 8'h21);
        any_ready = 1'b0;
        for (int i = 0; i < 60; i++) begin
            #1;
            if (req_ready !== 4'b0) any_ready = 1'b1;
            @(negedge sys_clk);
        end
        check("wait_ready_low", 32'(any_ready), 32'd0);
        req_valid = 4'b0001;
        accept("skip1", 4'b0001, 200, t);
        check("skip1_spacing", 32'(t - c5), 32'(SPACING));
        check("skip1_busy_fell", 32'(busy), 32'd0);
        @(negedge sys_clk);
        req_valid = 4'b0;
        wait_idle("skip1", 200);

        // Pointer wrap: grant 2, then 3 and 0 compete.
        @(negedge sys_clk);
        req_valid = 4'b0100;
        set_byte(2, 8'h32);
        accept("g2", 4'b0100, 5, prev);
        @(negedge sys_clk);
        req_valid = 4'b1001;
        set_byte(3, 8'h43);
        set_byte(0, 8'h40);
        accept("wrap3", 4'b1000, 200, t);
        check("wrap3_spacing", 32'(t - prev), 32'(SPACING));
        prev = t;
        @(negedge sys_clk);
        req_valid = 4'b0001;
        accept("wrap0", 4'b0001, 200, t);
        check("wrap0_spacing", 32'(t - prev), 32'(SPACING));
        @(negedge sys_clk);
        req_valid = 4'b0;

        // Reset at frame cycle 50 aborts the frame.
        repeat (49) @(negedge sys_clk);
        sys_rst = 1'b1;
        @(negedge sys_clk);
        #1;
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_tx_start", 32'(tx_start), 32'd0);
        check("mid_rst_tx_data", 32'(tx_data), 32'h00);
        check("mid_rst_grant_id", 32'(grant_id), 32'd0);
        check("mid_rst_rr_ptr", 32'(dut.rr_ptr), 32'd0);
        check("mid_rst_state", 32'(dut.state), 32'(IDLE));
        sys_rst   = 1'b0;
        req_valid = 4'b0010;
        set_byte(1, 8'h51);
        accept("post_rst", 4'b0010, 2, t);
        @(negedge sys_clk);
        req_valid = 4'b0;
        #1;
        check("post_rst_start", 32'(tx_start), 32'd1);
        wait_idle("post_rst", 200);
        @(negedge sys_clk);
        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares one 8N1 UART transmitter between NUM_REQ byte producers using round-robin arbitration.
- The transmitter has no busy or done output and reads its data input live during each bit. This block therefore latches the granted byte, holds it stable for the whole frame, and issues one start pulse.
- It then times out the full frame, plus a guard gap, with its own counter before granting again.
- Sits between the application sources and the transmitter's data/flag inputs.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- UART_BPS, 9600, serial baud rate; must match the transmitter.
- CLK_FREQ, 50_000_000, sys_clk frequency in Hz.
- GAP_BITS, 1, extra idle bit-times inserted after each stop bit.

Ports:
- sys_clk  in  1  system clock.
- sys_rst  in  1  synchronous, active-high reset.
- req_valid  in  NUM_REQ  bit i set: requester i has a byte pending.
- req_data  in  8*NUM_REQ  byte for requester i at [8*i+7:8*i].
- req_ready  out  NUM_REQ  one-hot, 1-cycle pulse: byte of requester i accepted this cycle.
- tx_data  out  8  byte to the transmitter; stable for the whole frame.
- tx_start  out  1  1-cycle start pulse to the transmitter.
- busy  out  1  high from accept until the frame and gap have elapsed.
- grant_id  out  clog2(NUM_REQ)  index of the last granted requester.

Behaviour:
- Constants:
  - BAUD_CNT_MAX = CLK_FREQ/UART_BPS (integer division).
  - FRAME_CYCLES = (10+GAP_BITS)*BAUD_CNT_MAX + 2. The +2 covers the transmitter's flag-to-enable and bit_flag pipeline delay.
  - CNT_W = clog2(FRAME_CYCLES+1).
- Reset (sync, sys_rst=1 at a sys_clk edge):
  - state=IDLE; rr_ptr=0; frame_cnt=0.
  - tx_data=8'h00; tx_start=0; busy=0; grant_id=0; req_ready=0.
- FSM states: IDLE, START, WAIT.
- IDLE:
  - If any req_valid bit is set, the grant g is the first set bit searching upward from rr_ptr, wrapping modulo NUM_REQ.
  - Same cycle: req_ready[g]=1 (combinational from state and req_valid). On the clock edge: tx_data<=req_data[g], grant_id<=g, busy<=1, state<=START.
  - With no valid bits set, the block stays in IDLE.
- START:
  - tx_start=1 for exactly this cycle.
  - frame_cnt<=FRAME_CYCLES-1; state<=WAIT.
- WAIT:
  - frame_cnt decrements by 1 each cycle.
  - When frame_cnt==0: state<=IDLE, busy<=0, rr_ptr<=(grant_id+1) mod NUM_REQ, wrapping from NUM_REQ-1 to 0.
- req_ready is 0 in START and WAIT regardless of req_valid. Requesters hold valid and data until they see ready; a byte is transferred only when valid and ready are both 1.
- Latency:
  - The accept cycle is T.
  - tx_start is high at T+1.
  - busy falls at T+2+FRAME_CYCLES; the next accept can occur in that same IDLE cycle.
- tx_data changes only on an accept edge.
- A requester's valid dropping after acceptance has no effect on the frame in progress.
- Simultaneous valid from all requesters: grants rotate strictly starting at rr_ptr. No requester waits more than NUM_REQ-1 frames.
- A requester deasserting valid before being granted is legal; it is simply skipped.
- Reset mid-WAIT or mid-START: immediate return to IDLE with reset values. The transmitter shares sys_rst, so no partial frame resumes.
- Illegal parameter combination: BAUD_CNT_MAX<2 is rejected by an elaboration-time check.

Decomposition:
- Shared package uart_pkg:
  - function calc_baud_cnt_max(clk_freq, bps).
  - constant frame-bit count 10 (start + 8 data + stop).
  - FSM state enum {IDLE, START, WAIT}.
- One natural sub-module: rr_pick, the combinational round-robin first-set-bit finder.
  - Inputs: req vector, pointer.
  - Outputs: any, index.
  - Reusable by other arbiters.

Test Plan:
Simulation parameters: CLK_FREQ=1_000_000, UART_BPS=100_000, GAP_BITS=1, giving BAUD_CNT_MAX=10 and FRAME_CYCLES=112.
- Single request: req_valid=4'b0100, data[2]=8'hA5 at cycle 0 -> req_ready=4'b0100 at cycle 0; tx_start=1 at cycle 1 only; tx_data=8'hA5 constant; busy=0 at cycle 114. Transmitter line shows start bit, then 1,0,1,0,0,1,0,1, then stop.
- All four valid continuously from reset (bytes 8'h10, 11, 12, 13) -> grant order 0,1,2,3,0. Accepts spaced 114 cycles apart. tx_data sequence 10,11,12,13,10.
- Pointer wrap: rr_ptr=3 after granting 2; valid=4'b1001 -> grant 3, then 0.
- Request asserted during WAIT -> req_ready stays 0 until IDLE; accepted exactly in the cycle busy falls.
- Requester 1 drops valid before its turn, with valid=4'b0011 and rr_ptr=1 -> grant goes to 0; requester 1 is not acknowledged.
- sys_rst=1 at frame cycle 50 -> the next cycle shows state=IDLE, busy=0, tx_start=0, tx_data=8'h00, rr_ptr=0. With valid=4'b0010 after release, requester 1 is granted one cycle later.
